regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single write port of the 64x32 register file (`regfile64by32bit`) between two producers:
- the in-order writeback stage (WB);
- the out-of-order late-result path (LD: load returns, multi-cycle ops).

WB always has priority. LD results are queued in a small FIFO and drained into idle write slots. A starvation counter forces a drain when WB saturates the port. Hazard flags tell decode when a source register has a queued but unwritten result.

## Interface
Parameters:
- `AW`, 6, register address width
- `DW`, 32, data width
- `DEPTH`, 4, LD pending FIFO entries (power of 2, >= 2)
- `STARVE_MAX`, 8, consecutive cycles a non-empty FIFO may be blocked by WB before a forced drain

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `wb_we`  in  1  WB write request
- `wb_rw`  in  AW  WB destination register
- `wb_din`  in  DW  WB write data
- `wb_stall`  out  1  WB must hold its request this cycle (forced drain)
- `ld_valid`  in  1  LD result valid
- `ld_ready`  out  1  FIFO can accept an LD result
- `ld_rw`  in  AW  LD destination register
- `ld_din`  in  DW  LD data
- `rd_ra`, `rd_rb`  in  AW  decode source addresses (same as regfile `Ra`/`Rb`)
- `pend_hit_a`, `pend_hit_b`  out  1  source matches a queued LD entry
- `pend_count`  out  log2(DEPTH)+1  FIFO occupancy
- `rf_we`, `rf_rw`, `rf_din`  out  1/AW/DW  regfile `regwe`/`Rw`/`Din`

## Operation
- **Write port outputs** (`rf_*`) are registered. Each rising edge selects, in priority order:
  1. `wb_stall`=1 and FIFO non-empty: pop head into `rf_*`, `rf_we`=1; `wb_we` is ignored.
  2. `wb_we`=1: `rf_*` <= WB request, `rf_we`=1.
  3. FIFO non-empty: pop head, `rf_we`=1.
  4. Otherwise `rf_we`=0; `rf_rw`/`rf_din` hold their values.
- **LD push:**
  - An entry is pushed on an edge where `ld_valid && ld_ready`.
  - `ld_ready` = (count < DEPTH), computed from registered count. There is no push-while-full, even with a simultaneous pop.
  - Push and pop may occur on the same edge when not full; count is unchanged.
  - A pushed entry can never be popped on the edge that pushed it.
- **Ordering:** FIFO order is preserved. Two queued writes to the same register land in arrival order, so the last one wins.
- **Starvation counter:**
  - Increments on each edge where the FIFO is non-empty and WB took the port.
  - Clears on any pop or when the FIFO is empty.
  - When it reaches STARVE_MAX, `wb_stall` is registered to 1 for exactly one cycle and the counter clears.
- **Hazard flags:** combinational compare of `rd_ra`/`rd_rb` against the `rw` of every valid FIFO entry.
- **Reset** (asynchronous, any time, including mid-drain): every queued entry is discarded. All outputs are 0: `rf_we`, `rf_rw`, `rf_din`, `wb_stall`, `pend_hit_*`, `pend_count`. `ld_ready` is 0 while reset is high and 1 from the first cycle after release.

## Timing
- WB request to `rf_we` high: 1 cycle. The regfile write lands on the following edge.
- LD accept to `rf_we` high: minimum 2 cycles (empty FIFO, WB idle). Worst case, when WB is continuously busy: STARVE_MAX+1 cycles per entry ahead in queue.
- `ld_ready` drops the cycle after count reaches DEPTH. It rises the cycle after a pop frees a slot.
- `pend_hit_*` clears the cycle after the matching entry is popped into `rf_*`. Decode must still allow one further cycle for the regfile write to land.
- `wb_stall` is 1 cycle wide and is never asserted while the FIFO is empty.

## Configuration
- `RFARB_HAZARD_EN` defined: the hazard comparators are built and `pend_hit_a`/`pend_hit_b` behave as specified.
- Undefined: the comparators are omitted and both outputs are tied to 0. Decode must then stall on any outstanding LD by other means.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with `wb_we`=1 and `ld_valid`=1 -> all outputs 0, no push, `ld_ready`=1 one cycle after release.
- **WB only:** `wb_we`=1, `wb_rw`=1, `wb_din`=DEADBEEF -> next cycle `rf_we`=1, `rf_rw`=1, `rf_din`=DEADBEEF; drop `wb_we` -> `rf_we`=0.
- **LD drain:** WB idle, push LD r2=BAADBEEF -> `pend_count`=1, `pend_hit_a`=1 with `rd_ra`=2 (hazard build); 2 cycles after accept `rf_we`=1, `rf_rw`=2; then `pend_count`=0 and `pend_hit_a`=0.
- **Full/backpressure:** WB busy, push 4 LD entries r3..r6 -> `ld_ready`=0 and a 5th `ld_valid` is not accepted. Release WB -> drain order r3, r4, r5, r6 on consecutive cycles.
- **Starvation:** `wb_we`=1 every cycle with 1 entry queued -> `wb_stall`=1 exactly once after STARVE_MAX=8 blocked cycles, LD entry written that cycle, WB data of that cycle not written.
- **Reset mid-drain:** 3 entries queued, assert `reset` asynchronously between edges -> `rf_we` and `pend_count` go to 0 immediately; after release no queued entry is ever written.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of the 64x32 register file between the in-order
//   writeback stage (WB, always highest priority) and the out-of-order late-result
//   path (LD). LD results queue in a small FIFO and drain into idle write slots; a
//   starvation counter forces one drain when WB keeps the port busy too long.
//
//   Optional build macro: RFARB_HAZARD_EN builds the pending-register comparators
//   behind pend_hit_a/pend_hit_b; when undefined both outputs are tied to 0.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   wb_we, wb_rw, wb_din       WB write request
//   wb_stall                   WB must hold its request this cycle (forced drain)
//   ld_valid, ld_rw, ld_din    LD result; accepted when ld_ready is high
//   ld_ready                   FIFO can accept an LD result
//   rd_ra, rd_rb               decode source addresses
//   pend_hit_a, pend_hit_b     source matches a queued LD entry
//   pend_count                 FIFO occupancy
//   rf_we, rf_rw, rf_din       registered regfile write port
module regfile_write_arbiter #(
  parameter int unsigned AW         = 6,
  parameter int unsigned DW         = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_we,
  input  logic [AW-1:0]              wb_rw,
  input  logic [DW-1:0]              wb_din,
  output logic                       wb_stall,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [AW-1:0]              ld_rw,
  input  logic [DW-1:0]              ld_din,
  input  logic [AW-1:0]              rd_ra,
  input  logic [AW-1:0]              rd_rb,
  output logic                       pend_hit_a,
  output logic                       pend_hit_b,
  output logic [$clog2(DEPTH):0]     pend_count,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_rw,
  output logic [DW-1:0]              rf_din
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]    fifo_rw  [DEPTH];
  logic [DW-1:0]    fifo_din [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_d;
  // Low only during and for the first cycle after reset, so ld_ready stays low then.
  logic             ready_en_q;
  logic             empty, push, pop;

  assign empty      = (count_q == '0);
  assign ld_ready   = ready_en_q && (count_q < CW'(DEPTH));
  assign push       = ld_valid && ld_ready;
  // A forced drain overrides WB; otherwise the FIFO only gets WB-idle slots.
  // Pop uses registered occupancy, so an entry is never popped on its push edge.
  assign pop        = !empty && (wb_stall || !wb_we);
  assign pend_count = count_q;

  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    // Non-empty and not popping means WB took the port this edge.
    if (!empty && !pop) begin
      if (starve_q == SW'(STARVE_MAX - 1)) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    // Push and pop never target the same slot: push needs not-full, pop needs non-empty.
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
  end

  // Payload storage needs no reset; valid_q qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[tail_q]  <= ld_rw;
      fifo_din[tail_q] <= ld_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_rw      <= '0;
      rf_din     <= '0;
      wb_stall   <= 1'b0;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      wb_stall   <= stall_d;
      starve_q   <= starve_d;
      valid_q    <= valid_d;
      count_q    <= count_q + CW'(push) - CW'(pop);
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (pop) begin
        rf_we  <= 1'b1;
        rf_rw  <= fifo_rw[head_q];
        rf_din <= fifo_din[head_q];
      end else if (wb_we) begin
        rf_we  <= 1'b1;
        rf_rw  <= wb_rw;
        rf_din <= wb_din;
      end else begin
        rf_we  <= 1'b0;
      end
    end
  end

`ifdef RFARB_HAZARD_EN
  always_comb begin
    pend_hit_a = 1'b0;
    pend_hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (fifo_rw[i] == rd_ra)) pend_hit_a = 1'b1;
      if (valid_q[i] && (fifo_rw[i] == rd_rb)) pend_hit_b = 1'b1;
    end
  end
`else
  assign pend_hit_a = 1'b0;
  assign pend_hit_b = 1'b0;
  logic unused_rd;
  assign unused_rd = ^{rd_ra, rd_rb};
`endif

endmodule
